// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity-sense constants.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

    localparam int UART_PAR_EVEN = 0;
    localparam int UART_PAR_ODD  = 1;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with valid/ready output holding, frame/parity error and overrun reporting.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 217,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serialData,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int               CNT_W     = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]       IDX_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       IDX_SLAST = 4'(STOP_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (serialData),
        .dout (rx_s)
    );

    assign busy_o = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD == UART_PAR_ODD);
    logic perr;
    logic parity_err_q;
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            ferr        <= 1'b0;
            dataout     <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr         <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            overrun_o <= 1'b0;
            // Completion below overrides this clear when a new word is loaded.
            if (valid_o && ready_i)
                valid_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt  <= '0;
                    idx  <= '0;
                    ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr <= 1'b0;
`endif
                    if (!rx_s)
                        state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == IDX_DLAST) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else
                            idx <= idx + 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        perr  <= rx_s ^ (^shreg) ^ PAR_SENSE;
                        state <= ST_STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_SLAST) begin
                            idx   <= '0;
                            // A line still low here is a break; wait for idle before re-arming.
                            state <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
                            if (!valid_o || ready_i) begin
                                dataout     <= shreg;
                                valid_o     <= 1'b1;
                                frame_err_o <= ferr | ~rx_s;
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= perr;
`endif
                            end else
                                overrun_o <= 1'b1;
                        end else begin
                            idx  <= idx + 1'b1;
                            ferr <= ferr | ~rx_s;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
